vga_scan_gen: RTL and testbench

//  Generates the 640x480@60Hz VGA raster: pixel-tick divider, horizontal and vertical

---
 rtl/vga_scan_gen.sv | 116 +++++++++++
 tb/tb_vga_scan_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// VGA raster generator: pixel-tick divider, h/v counters, registered sync/enable/coordinates.
// Optional macro VGA_SYNC_DELAY_EN delays hs/vs/rdn by one pixel tick to align with a registered ROM lookup.
module vga_scan_gen #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  output logic [9:0] col_addr,
  output logic [8:0] row_addr,
  output logic       rdn,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]    HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]    VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt, div_nxt;
  logic [9:0]    h_cnt, h_nxt;
  logic [9:0]    v_cnt, v_nxt;
  logic          tick, h_wrap, frame_wrap;
  logic          vis_nxt, hs_nxt, vs_nxt;

  // Outputs decode the post-update counters so they change on the same edge as the counters.
  always_comb begin
    tick       = scan_en && (div_cnt == DIV_LAST);
    h_wrap     = tick && (h_cnt == H_LAST);
    frame_wrap = h_wrap && (v_cnt == V_LAST);
    div_nxt    = div_cnt;
    h_nxt      = h_cnt;
    v_nxt      = v_cnt;
    if (scan_en) div_nxt = tick ? '0 : div_cnt + 1'b1;
    if (tick)    h_nxt   = h_wrap ? '0 : h_cnt + 10'd1;
    if (h_wrap)  v_nxt   = frame_wrap ? '0 : v_cnt + 10'd1;
    vis_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    hs_nxt  = !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
    vs_nxt  = !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      col_addr    <= '0;
      row_addr    <= '0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      col_addr    <= vis_nxt ? h_nxt : '0;
      row_addr    <= vis_nxt ? v_nxt[8:0] : '0;
      frame_start <= frame_wrap;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_raw, vs_raw, rdn_raw;

  // Second stage only moves on a tick, giving exactly one pixel of lag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_raw  <= 1'b1;
      vs_raw  <= 1'b1;
      rdn_raw <= 1'b0;
      hs      <= 1'b1;
      vs      <= 1'b1;
      rdn     <= 1'b0;
    end else begin
      hs_raw  <= hs_nxt;
      vs_raw  <= vs_nxt;
      rdn_raw <= !vis_nxt;
      if (tick) begin
        hs  <= hs_raw;
        vs  <= vs_raw;
        rdn <= rdn_raw;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs  <= 1'b1;
      vs  <= 1'b1;
      rdn <= 1'b0;
    end else begin
      hs  <= hs_nxt;
      vs  <= vs_nxt;
      rdn <= !vis_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen on a shrunken raster (24x12 ticks, DIV=4) so whole frames fit in the run.
module tb_vga_scan_gen;

  localparam int DIV = 4;
  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 6,  VFP = 2, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;   // 24
  localparam int VT = VA + VFP + VSY + VBP;   // 12
  localparam int FRAME_CLKS = HT * VT * DIV;  // 1152
`ifdef VGA_SYNC_DELAY_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_en = 1'b0;
  logic [9:0] col_addr;
  logic [8:0] row_addr;
  logic       rdn, hs, vs, frame_start;

  int n_checks = 0;
  int n_fail = 0;

  int   m_div = 0, m_h = 0, m_v = 0;
  logic m_fs = 1'b0;
  logic d_hs = 1'b1, d_vs = 1'b1, d_rdn = 1'b0;

  vga_scan_gen #(
    .DIV(DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en),
    .col_addr(col_addr), .row_addr(row_addr), .rdn(rdn),
    .hs(hs), .vs(vs), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic f_vis(int h, int v);
    return (h < HA) && (v < VA);
  endfunction
  function automatic logic f_hs(int h);
    return !((h >= HA + HFP) && (h < HA + HFP + HSY));
  endfunction
  function automatic logic f_vs(int v);
    return !((v >= VA + VFP) && (v < VA + VFP + VSY));
  endfunction

  function automatic logic [9:0] e_col();
    return f_vis(m_h, m_v) ? 10'(m_h) : 10'd0;
  endfunction
  function automatic logic [8:0] e_row();
    return f_vis(m_h, m_v) ? 9'(m_v) : 9'd0;
  endfunction
  function automatic logic e_rdn();
`ifdef VGA_SYNC_DELAY_EN
    return d_rdn;
`else
    return !f_vis(m_h, m_v);
`endif
  endfunction
  function automatic logic e_hs();
`ifdef VGA_SYNC_DELAY_EN
    return d_hs;
`else
    return f_hs(m_h);
`endif
  endfunction
  function automatic logic e_vs();
`ifdef VGA_SYNC_DELAY_EN
    return d_vs;
`else
    return f_vs(m_v);
`endif
  endfunction

  // Advance one clock (inputs already set) and update the reference raster.
  task automatic clk1();
    @(negedge clk);
    if (!rst_n) begin
      m_div = 0; m_h = 0; m_v = 0; m_fs = 1'b0;
      d_hs = 1'b1; d_vs = 1'b1; d_rdn = 1'b0;
    end else if (scan_en) begin
      m_fs = 1'b0;
      if (m_div == DIV - 1) begin
        d_hs = f_hs(m_h); d_vs = f_vs(m_v); d_rdn = !f_vis(m_h, m_v);
        m_div = 0;
        if (m_h == HT - 1) begin
          m_h = 0;
          if (m_v == VT - 1) begin m_v = 0; m_fs = 1'b1; end
          else m_v = m_v + 1;
        end else m_h = m_h + 1;
      end else m_div = m_div + 1;
    end else m_fs = 1'b0;
  endtask

  task automatic run_until(int h, int v, int d);
    int n;
    n = 0;
    while (!(m_h == h && m_v == v && m_div == d) && n < 2 * FRAME_CLKS) begin
      clk1();
      n++;
    end
    n_checks++;
    if (!(m_h == h && m_v == v && m_div == d)) begin
      n_fail++;
      $display("FAIL run_until timeout: reached h=%0d v=%0d div=%0d, required h=%0d v=%0d div=%0d", m_h, m_v, m_div, h, v, d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan_en = 1'b1;
    repeat (3) clk1();
    n_checks += 6;
    if (col_addr !== 10'd0)   begin n_fail++; $display("FAIL reset_col: got %0d want 0", col_addr); end
    if (row_addr !== 9'd0)    begin n_fail++; $display("FAIL reset_row: got %0d want 0", row_addr); end
    if (rdn !== 1'b0)         begin n_fail++; $display("FAIL reset_rdn: got %b want 0", rdn); end
    if (hs !== 1'b1)          begin n_fail++; $display("FAIL reset_hs: got %b want 1", hs); end
    if (vs !== 1'b1)          begin n_fail++; $display("FAIL reset_vs: got %b want 1", vs); end
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b want 0", frame_start); end
  endtask

  task automatic test_first_pixels();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      clk1();
      n_checks += 3;
      if (col_addr !== 10'(k / 4)) begin n_fail++; $display("FAIL first_col clk %0d: got %0d want %0d", k, col_addr, k / 4); end
      if (rdn !== 1'b0) begin n_fail++; $display("FAIL first_rdn clk %0d: got %b want 0", k, rdn); end
      if (hs !== 1'b1)  begin n_fail++; $display("FAIL first_hs clk %0d: got %b want 1", k, hs); end
    end
  endtask

  task automatic test_frame();
    logic p_hs, p_vs, p_rdn;
    int hs_run, vs_run, n_fs, fs_first, fs_last;
    p_hs = 1'b1; p_vs = 1'b1; p_rdn = 1'b0;
    hs_run = 0; vs_run = 0; n_fs = 0; fs_first = -1; fs_last = -1;
    for (int c = 0; c < 2 * FRAME_CLKS + 200; c++) begin
      clk1();
      n_checks += 6;
      if (col_addr !== e_col())  begin n_fail++; $display("FAIL frame_col h=%0d v=%0d: got %0d want %0d", m_h, m_v, col_addr, e_col()); end
      if (row_addr !== e_row())  begin n_fail++; $display("FAIL frame_row h=%0d v=%0d: got %0d want %0d", m_h, m_v, row_addr, e_row()); end
      if (rdn !== e_rdn())       begin n_fail++; $display("FAIL frame_rdn h=%0d v=%0d: got %b want %b", m_h, m_v, rdn, e_rdn()); end
      if (hs !== e_hs())         begin n_fail++; $display("FAIL frame_hs h=%0d v=%0d: got %b want %b", m_h, m_v, hs, e_hs()); end
      if (vs !== e_vs())         begin n_fail++; $display("FAIL frame_vs h=%0d v=%0d: got %b want %b", m_h, m_v, vs, e_vs()); end
      if (frame_start !== m_fs)  begin n_fail++; $display("FAIL frame_fs h=%0d v=%0d: got %b want %b", m_h, m_v, frame_start, m_fs); end
      if (p_hs === 1'b1 && hs === 1'b0) begin
        n_checks++;
        if (m_h !== HA + HFP + LAG) begin n_fail++; $display("FAIL hs_fall_h: got h=%0d want %0d", m_h, HA + HFP + LAG); end
      end
      if (hs === 1'b0) hs_run++;
      else if (p_hs === 1'b0) begin
        n_checks++;
        if (hs_run !== HSY * DIV) begin n_fail++; $display("FAIL hs_width: got %0d clks want %0d", hs_run, HSY * DIV); end
        hs_run = 0;
      end
      if (vs === 1'b0) vs_run++;
      else if (p_vs === 1'b0) begin
        n_checks++;
        if (vs_run !== VSY * HT * DIV) begin n_fail++; $display("FAIL vs_width: got %0d clks want %0d", vs_run, VSY * HT * DIV); end
        vs_run = 0;
      end
      if (p_rdn === 1'b0 && rdn === 1'b1) begin
        n_checks++;
        if (m_h !== HA + LAG) begin n_fail++; $display("FAIL rdn_rise_h: got h=%0d want %0d", m_h, HA + LAG); end
      end
      if (frame_start === 1'b1) begin
        n_checks += 2;
        if (col_addr !== 10'd0) begin n_fail++; $display("FAIL fs_col: got %0d want 0", col_addr); end
        if (row_addr !== 9'd0)  begin n_fail++; $display("FAIL fs_row: got %0d want 0", row_addr); end
        if (fs_first < 0) fs_first = c;
        fs_last = c;
        n_fs++;
      end
      p_hs = hs; p_vs = vs; p_rdn = rdn;
    end
    n_checks += 2;
    if (n_fs !== 2) begin n_fail++; $display("FAIL fs_count: got %0d want 2", n_fs); end
    if (fs_last - fs_first !== FRAME_CLKS) begin n_fail++; $display("FAIL fs_period: got %0d clks want %0d", fs_last - fs_first, FRAME_CLKS); end
  endtask

  task automatic test_freeze();
    int n;
    run_until(10, 3, 2);
    scan_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      clk1();
      n_checks += 6;
      if (col_addr !== 10'd10)  begin n_fail++; $display("FAIL freeze_col: got %0d want 10", col_addr); end
      if (row_addr !== 9'd3)    begin n_fail++; $display("FAIL freeze_row: got %0d want 3", row_addr); end
      if (rdn !== 1'b0)         begin n_fail++; $display("FAIL freeze_rdn: got %b want 0", rdn); end
      if (hs !== 1'b1)          begin n_fail++; $display("FAIL freeze_hs: got %b want 1", hs); end
      if (vs !== 1'b1)          begin n_fail++; $display("FAIL freeze_vs: got %b want 1", vs); end
      if (frame_start !== 1'b0) begin n_fail++; $display("FAIL freeze_fs: got %b want 0", frame_start); end
    end
    scan_en = 1'b1;
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      clk1();
      if (col_addr === 10'd11) begin n = k; break; end
    end
    n_checks += 2;
    if (n !== DIV - 2) begin n_fail++; $display("FAIL resume_latency: got %0d clks want %0d", n, DIV - 2); end
    if (row_addr !== 9'd3) begin n_fail++; $display("FAIL resume_row: got %0d want 3", row_addr); end
  endtask

  task automatic test_reset_mid();
    run_until(10, 4, 1);
    rst_n = 1'b0;
    clk1();
    rst_n = 1'b1;
    n_checks += 6;
    if (col_addr !== 10'd0)   begin n_fail++; $display("FAIL midrst_col: got %0d want 0", col_addr); end
    if (row_addr !== 9'd0)    begin n_fail++; $display("FAIL midrst_row: got %0d want 0", row_addr); end
    if (rdn !== 1'b0)         begin n_fail++; $display("FAIL midrst_rdn: got %b want 0", rdn); end
    if (hs !== 1'b1)          begin n_fail++; $display("FAIL midrst_hs: got %b want 1", hs); end
    if (vs !== 1'b1)          begin n_fail++; $display("FAIL midrst_vs: got %b want 1", vs); end
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL midrst_fs: got %b want 0", frame_start); end
    for (int k = 1; k <= 9; k++) begin
      clk1();
      n_checks += 2;
      if (col_addr !== 10'(k / 4)) begin n_fail++; $display("FAIL midrst_restart_col clk %0d: got %0d want %0d", k, col_addr, k / 4); end
      if (row_addr !== 9'd0) begin n_fail++; $display("FAIL midrst_restart_row clk %0d: got %0d want 0", k, row_addr); end
    end
  endtask

  initial begin
    test_reset();
    test_first_pixels();
    test_frame();
    test_freeze();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
